// File: rtl/scroll_message_controller.sv
// Scrolls MSG across a two-digit display, one character step every CLKS_PER_STEP clocks.
// Define SCROLL_ONESHOT_EN to stop after one full pass instead of wrapping continuously.
module scroll_message_controller #(
  parameter int unsigned               CLKS_PER_STEP = 12500000,
  parameter int unsigned               MSG_LEN       = 5,
  parameter logic [MSG_LEN*8-1:0]      MSG           = "HELLO"
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic       i_Stop,
  input  logic       i_Pause,
  output logic [7:0] o_Char_Left,
  output logic [7:0] o_Char_Right,
  output logic       o_Busy,
  output logic       o_Wrap
);

  localparam int unsigned TW = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP + 1) : 1;
  localparam int unsigned PW = (MSG_LEN > 1) ? $clog2(MSG_LEN + 1) : 1;
  localparam logic [TW-1:0] TIMER_TERM = TW'(CLKS_PER_STEP - 1);
  localparam logic [PW-1:0] POS_LAST   = PW'(MSG_LEN);
  localparam logic [7:0]    BLANK      = 8'h20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    left_q, left_d;
  logic [7:0]    right_q, right_d;
  logic          busy_q, busy_d;
  logic          wrap_q, wrap_d;

  // Characters beyond the message read as blanks so the text scrolls fully off-screen.
  function automatic logic [7:0] stream_char(input int unsigned k);
    logic [7:0] c;
    c = BLANK;
    for (int unsigned i = 0; i < MSG_LEN; i++) begin
      if (i == k) c = MSG[(MSG_LEN-1-i)*8 +: 8];
    end
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    timer_d = timer_q;
    wrap_d  = 1'b0;

    if (i_Stop) begin
      state_d = IDLE;
      pos_d   = '0;
      timer_d = '0;
    end else if (i_Start) begin
      state_d = i_Pause ? PAUSE : RUN;
      pos_d   = '0;
      timer_d = '0;
    end else if (state_q != IDLE) begin
      state_d = i_Pause ? PAUSE : RUN;
      // Leaving PAUSE counts in the same cycle, so the timer picks up where it froze.
      if (!i_Pause) begin
        if (timer_q == TIMER_TERM) begin
          timer_d = '0;
          if (pos_q == POS_LAST) begin
            pos_d  = '0;
            wrap_d = 1'b1;
`ifdef SCROLL_ONESHOT_EN
            state_d = IDLE;
`endif
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
    end

    busy_d = (state_d != IDLE);
    if (busy_d) begin
      left_d  = stream_char(32'(pos_d));
      right_d = stream_char(32'(pos_d) + 1);
    end else begin
      left_d  = BLANK;
      right_d = BLANK;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= IDLE;
      pos_q   <= '0;
      timer_q <= '0;
      left_q  <= BLANK;
      right_q <= BLANK;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      timer_q <= timer_d;
      left_q  <= left_d;
      right_q <= right_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_Char_Left  = left_q;
  assign o_Char_Right = right_q;
  assign o_Busy       = busy_q;
  assign o_Wrap       = wrap_q;

endmodule

// File: tb/tb_scroll_message_controller.sv
// Directed bench for scroll_message_controller with CLKS_PER_STEP=4 and "HELLO".
module tb_scroll_message_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] left, right;
  logic       busy, wrap;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Expected {left, right} for positions 0..5, then 0 again.
  logic [15:0] exp_lr [0:6] = '{16'h4845, 16'h454C, 16'h4C4C, 16'h4C4F,
                                16'h4F20, 16'h2020, 16'h4845};
  logic [17:0] obs;
  logic [17:0] exp_v;

  scroll_message_controller #(
    .CLKS_PER_STEP(4),
    .MSG_LEN(5),
    .MSG("HELLO")
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .i_Start(start),
    .i_Stop(stop),
    .i_Pause(pause),
    .o_Char_Left(left),
    .o_Char_Right(right),
    .o_Busy(busy),
    .o_Wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    obs = {left, right, busy, wrap};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    total++;
    if (obs !== {16'h2020, 2'b00}) begin
      bad++; $display("FAIL reset_idle got=%h want=%h", obs, {16'h2020, 2'b00});
    end
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    // Asynchronous assertion mid-cycle must clear outputs before the next edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    obs = {left, right, busy, wrap};
    total++;
    if (obs !== {16'h2020, 2'b00}) begin
      bad++; $display("FAIL reset_async got=%h want=%h", obs, {16'h2020, 2'b00});
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++;
    if (obs !== {16'h2020, 2'b00}) begin
      bad++; $display("FAIL reset_release got=%h want=%h", obs, {16'h2020, 2'b00});
    end
  endtask

  task automatic test_scroll();
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if (obs !== {exp_lr[0], 2'b10}) begin
      bad++; $display("FAIL scroll_start got=%h want=%h", obs, {exp_lr[0], 2'b10});
    end
    for (int i = 1; i <= 5; i++) begin
      repeat (3) tick();
      total++;
      if (obs !== {exp_lr[i-1], 2'b10}) begin
        bad++; $display("FAIL scroll_hold%0d got=%h want=%h", i, obs, {exp_lr[i-1], 2'b10});
      end
      tick();
      total++;
      if (obs !== {exp_lr[i], 2'b10}) begin
        bad++; $display("FAIL scroll_step%0d got=%h want=%h", i, obs, {exp_lr[i], 2'b10});
      end
    end
  endtask

  task automatic test_wrap();
    repeat (4) tick();
`ifdef SCROLL_ONESHOT_EN
    exp_v = {16'h2020, 2'b01};
`else
    exp_v = {exp_lr[6], 2'b11};
`endif
    total++;
    if (obs !== exp_v) begin
      bad++; $display("FAIL wrap_pulse got=%h want=%h", obs, exp_v);
    end
    tick();
`ifdef SCROLL_ONESHOT_EN
    exp_v = {16'h2020, 2'b00};
`else
    exp_v = {exp_lr[6], 2'b10};
`endif
    total++;
    if (obs !== exp_v) begin
      bad++; $display("FAIL wrap_one_cycle got=%h want=%h", obs, exp_v);
    end
`ifdef SCROLL_ONESHOT_EN
    repeat (30) tick();
    total++;
    if (obs !== exp_v) begin
      bad++; $display("FAIL oneshot_stays_idle got=%h want=%h", obs, exp_v);
    end
`else
    repeat (22) tick();
    total++;
    if (obs !== {16'h2020, 2'b10}) begin
      bad++; $display("FAIL wrap_second_pre got=%h want=%h", obs, {16'h2020, 2'b10});
    end
    tick();
    total++;
    if (obs !== {exp_lr[6], 2'b11}) begin
      bad++; $display("FAIL wrap_second got=%h want=%h", obs, {exp_lr[6], 2'b11});
    end
`endif
  endtask

  task automatic test_pause();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    pause = 1'b1;
    repeat (10) tick();
    total++;
    if (obs !== {exp_lr[0], 2'b10}) begin
      bad++; $display("FAIL pause_held got=%h want=%h", obs, {exp_lr[0], 2'b10});
    end
    pause = 1'b0;
    repeat (2) tick();
    total++;
    if (obs !== {exp_lr[0], 2'b10}) begin
      bad++; $display("FAIL pause_resume_hold got=%h want=%h", obs, {exp_lr[0], 2'b10});
    end
    tick();
    total++;
    if (obs !== {exp_lr[1], 2'b10}) begin
      bad++; $display("FAIL pause_resume_step got=%h want=%h", obs, {exp_lr[1], 2'b10});
    end
  endtask

  task automatic test_start_stop();
    tick();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    total++;
    if (obs !== {16'h2020, 2'b00}) begin
      bad++; $display("FAIL start_stop_idle got=%h want=%h", obs, {16'h2020, 2'b00});
    end
    repeat (5) tick();
    total++;
    if (obs !== {16'h2020, 2'b00}) begin
      bad++; $display("FAIL start_stop_stays got=%h want=%h", obs, {16'h2020, 2'b00});
    end
  endtask

  task automatic test_restart();
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    total++;
    if (obs !== {exp_lr[1], 2'b10}) begin
      bad++; $display("FAIL restart_pre got=%h want=%h", obs, {exp_lr[1], 2'b10});
    end
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if (obs !== {exp_lr[0], 2'b10}) begin
      bad++; $display("FAIL restart_pos0 got=%h want=%h", obs, {exp_lr[0], 2'b10});
    end
    repeat (3) tick();
    total++;
    if (obs !== {exp_lr[0], 2'b10}) begin
      bad++; $display("FAIL restart_hold got=%h want=%h", obs, {exp_lr[0], 2'b10});
    end
    tick();
    total++;
    if (obs !== {exp_lr[1], 2'b10}) begin
      bad++; $display("FAIL restart_step got=%h want=%h", obs, {exp_lr[1], 2'b10});
    end
    stop = 1'b1; tick(); stop = 1'b0;
    total++;
    if (obs !== {16'h2020, 2'b00}) begin
      bad++; $display("FAIL stop_idle got=%h want=%h", obs, {16'h2020, 2'b00});
    end
    pause = 1'b1; start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    total++;
    if (obs !== {exp_lr[0], 2'b10}) begin
      bad++; $display("FAIL start_paused got=%h want=%h", obs, {exp_lr[0], 2'b10});
    end
    pause = 1'b0;
    repeat (4) tick();
    total++;
    if (obs !== {exp_lr[1], 2'b10}) begin
      bad++; $display("FAIL start_paused_run got=%h want=%h", obs, {exp_lr[1], 2'b10});
    end
  endtask

  initial begin
    test_reset();
    test_scroll();
    test_wrap();
    test_pause();
    test_start_stop();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
